next_pc_unit: RTL and testbench

Generates the fetch PC that drives the IF stage's PC input, which is the producer side of the PC interface the fetch stage consumes. It selects between sequential fetch, branch, jump, jump-register and exception redirects. It holds the PC under pipeline stall and parks a redirect that arrives during a stall until the stall releases. It also issues the IF/ID flush strobes and keeps a saturating redirect counter for performance debug.

---
 rtl/next_pc_unit.sv | 177 +++++++++++++++++
 tb/tb_next_pc_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// next_pc_unit: fetch PC generator for the IF stage.
// Selects sequential fetch or a redirect (exception, branch, jump-register,
// jump), holds the PC while the hazard unit stalls, parks a redirect that
// arrives during a stall until the stall releases, issues IF/ID flush
// strobes and keeps a saturating count of applied redirects.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   stall          hold request from hazard unit
//   branch_taken   EX-stage branch resolved taken
//   branch_target  EX-stage branch target
//   jump           J/JAL decoded in ID
//   jump_index     26-bit instruction index from ID
//   jump_pc_plus_4 PC+4 of the jump instruction
//   jr             JR/JALR decoded in ID
//   jr_target      register value for JR
//   exception      exception request, highest priority
//   PC             current fetch address (registered)
//   flush_IF       kill IF/ID contents (combinational from inputs)
//   flush_ID       kill ID/EX contents (combinational from inputs)
//   addr_err       one-cycle pulse after a misaligned JR target
//   pending        a redirect is parked awaiting stall release
//   redirect_cnt   saturating count of applied redirects
module next_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0004,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic [31:0]      jump_pc_plus_4,
  input  logic             jr,
  input  logic [31:0]      jr_target,
  input  logic             exception,
  output logic [31:0]      PC,
  output logic             flush_IF,
  output logic             flush_ID,
  output logic             addr_err,
  output logic             pending,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]  state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] stored_tgt, stored_tgt_nxt;
  logic        addr_err_nxt;
  logic        cnt_inc;
  logic        flush_if_raw, flush_id_raw;

  // Candidate redirect targets, word-aligned.
  logic [31:0] br_tgt, j_tgt, jr_tgt;
  logic        jr_misaligned;

  assign br_tgt        = {branch_target[31:2], 2'b00};
  assign j_tgt         = {jump_pc_plus_4[31:28], jump_index, 2'b00};
  assign jr_tgt        = {jr_target[31:2], 2'b00};
  assign jr_misaligned = |jr_target[1:0];

  // Low bits that target formation deliberately discards.
  logic unused_bits;
  assign unused_bits = ^{branch_target[1:0], jump_pc_plus_4[27:0]};

  // Highest-priority non-exception redirect seen while running.
  logic        run_redir;
  logic [31:0] run_tgt;

  assign run_redir = branch_taken | jr | jump;

  always_comb begin
    run_tgt = j_tgt;
    if (branch_taken) begin
      run_tgt = br_tgt;
    end else if (jr) begin
      run_tgt = jr_tgt;
    end
  end

  // State register and architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      PC           <= RESET_VECTOR;
      stored_tgt   <= 32'h0;
      addr_err     <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state      <= state_nxt;
      PC         <= pc_nxt;
      stored_tgt <= stored_tgt_nxt;
      addr_err   <= addr_err_nxt;
      if (cnt_inc && (redirect_cnt != CNT_MAX)) begin
        redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state, next-PC and flush decode.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = PC;
    stored_tgt_nxt = stored_tgt;
    addr_err_nxt   = 1'b0;
    cnt_inc        = 1'b0;
    flush_if_raw   = 1'b0;
    flush_id_raw   = 1'b0;

    if (exception) begin
      // Exception overrides stall and discards any parked target.
      pc_nxt         = EXC_VECTOR;
      state_nxt      = RUN;
      stored_tgt_nxt = 32'h0;
      flush_if_raw   = 1'b1;
      flush_id_raw   = 1'b1;
      cnt_inc        = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (run_redir) begin
            flush_id_raw = branch_taken;
            addr_err_nxt = ~branch_taken & jr & jr_misaligned;
            if (stall) begin
              stored_tgt_nxt = run_tgt;
              state_nxt      = PEND;
            end else begin
              pc_nxt       = run_tgt;
              flush_if_raw = 1'b1;
              cnt_inc      = 1'b1;
            end
          end else if (!stall) begin
            pc_nxt = PC + 32'd4;
          end
        end

        PEND: begin
          // Only an older EX branch may replace the parked target; younger
          // jr/jump in ID are ignored here.
          if (branch_taken) begin
            flush_id_raw = 1'b1;
            if (stall) begin
              stored_tgt_nxt = br_tgt;
            end else begin
              pc_nxt       = br_tgt;
              state_nxt    = RUN;
              flush_if_raw = 1'b1;
              cnt_inc      = 1'b1;
            end
          end else if (!stall) begin
            pc_nxt       = stored_tgt;
            state_nxt    = RUN;
            flush_if_raw = 1'b1;
            cnt_inc      = 1'b1;
          end
        end

        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  assign flush_IF = flush_if_raw & ~reset;
  assign flush_ID = flush_id_raw & ~reset;
  assign pending  = (state == PEND);

endmodule

// File: tb/tb_next_pc_unit.sv
// Testbench for next_pc_unit: directed test-plan sequence followed by random
// stimulus, checked every cycle against a behavioural model. A second
// instance with a 4-bit counter exercises counter saturation.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jr, exception;
  logic [31:0] branch_target, jump_pc_plus_4, jr_target;
  logic [25:0] jump_index;

  logic [31:0] pc_a, pc_b;
  logic        fif_a, fid_a, aerr_a, pend_a;
  logic        fif_b, fid_b, aerr_b, pend_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_valid = 0;
  bit          m_parked;
  logic [31:0] m_pc, m_tgt;
  bit          m_aerr;
  int          m_cnt;

  always #5 clk = ~clk;

  next_pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .jump_pc_plus_4(jump_pc_plus_4),
    .jr(jr), .jr_target(jr_target), .exception(exception),
    .PC(pc_a), .flush_IF(fif_a), .flush_ID(fid_a), .addr_err(aerr_a),
    .pending(pend_a), .redirect_cnt(cnt_a)
  );

  next_pc_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .jump_pc_plus_4(jump_pc_plus_4),
    .jr(jr), .jr_target(jr_target), .exception(exception),
    .PC(pc_b), .flush_IF(fif_b), .flush_ID(fid_b), .addr_err(aerr_b),
    .pending(pend_b), .redirect_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; jump = 0; jr = 0; exception = 0;
    branch_target = 32'h0; jump_index = 26'h0; jump_pc_plus_4 = 32'h0; jr_target = 32'h0;
  endtask

  // One clock: check outputs at negedge, then advance the model at posedge.
  task automatic tick();
    bit          e_fi, e_fd, n_park, n_aerr, redir;
    logic [31:0] n_pc, n_tgt, t;
    int          c16, c4;
    @(negedge clk);
    e_fi = 0; e_fd = 0; redir = 0; n_aerr = 0;
    n_pc = m_pc; n_park = m_parked; n_tgt = m_tgt;
    if (reset) begin
      n_pc = 32'h0; n_park = 0; n_tgt = 32'h0;
    end else if (exception) begin
      n_pc = 32'h8000_0004; n_park = 0; e_fi = 1; e_fd = 1; redir = 1;
    end else if (branch_taken) begin
      t = branch_target & 32'hFFFF_FFFC;
      e_fd = 1;
      if (stall) begin n_park = 1; n_tgt = t; end
      else begin n_pc = t; n_park = 0; e_fi = 1; redir = 1; end
    end else if (m_parked) begin
      if (!stall) begin n_pc = m_tgt; n_park = 0; e_fi = 1; redir = 1; end
    end else if (jr || jump) begin
      if (jr) t = jr_target & 32'hFFFF_FFFC;
      else    t = (jump_pc_plus_4 & 32'hF000_0000) | (32'(jump_index) * 4);
      n_aerr = jr && (jr_target % 4 != 0);
      if (stall) begin n_park = 1; n_tgt = t; end
      else begin n_pc = t; e_fi = 1; redir = 1; end
    end else if (!stall) begin
      n_pc = m_pc + 32'd4;
    end

    check("flush_IF", 32'(fif_a), 32'(e_fi));
    check("flush_ID", 32'(fid_a), 32'(e_fd));
    if (m_valid) begin
      c16 = (m_cnt > 65535) ? 65535 : m_cnt;
      c4  = (m_cnt > 15) ? 15 : m_cnt;
      check("pc", pc_a, m_pc);
      check("pending", 32'(pend_a), 32'(m_parked));
      check("addr_err", 32'(aerr_a), 32'(m_aerr));
      check("cnt16", 32'(cnt_a), c16);
      check("cnt4", 32'(cnt_b), c4);
      check("pc4", pc_b, m_pc);
    end

    @(posedge clk);
    m_pc = n_pc; m_parked = n_park; m_tgt = n_tgt;
    m_aerr = reset ? 1'b0 : n_aerr;
    m_cnt  = reset ? 0 : m_cnt + int'(redir);
    m_valid = 1;
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    check("rst_pc", pc_a, 32'h0);
    check("rst_cnt", 32'(cnt_a), 32'h0);

    // Sequential fetch
    repeat (4) tick();
    check("seq_pc", pc_a, 32'h10);

    // Branch
    branch_taken = 1; branch_target = 32'h0000_0203;
    tick();
    idle_inputs();
    check("br_pc", pc_a, 32'h200);
    check("br_cnt", 32'(cnt_a), 32'h1);

    // Jump
    jump = 1; jump_pc_plus_4 = 32'h4000_0010; jump_index = 26'h0000040;
    tick();
    idle_inputs();
    check("j_pc", pc_a, 32'h4000_0100);

    // JR during a three-cycle stall, released afterwards
    stall = 1; jr = 1; jr_target = 32'h300;
    tick();
    jr = 0;
    repeat (2) tick();
    check("park_pc", pc_a, 32'h4000_0100);
    check("park_pend", 32'(pend_a), 32'h1);
    stall = 0;
    tick();
    check("rel_pc", pc_a, 32'h300);
    check("rel_pend", 32'(pend_a), 32'h0);

    // Exception while parked and stalled, then misaligned JR
    stall = 1; jump = 1; jump_index = 26'h123;
    tick();
    jump = 0; exception = 1;
    tick();
    idle_inputs();
    check("exc_pc", pc_a, 32'h8000_0004);
    jr = 1; jr_target = 32'h302;
    tick();
    idle_inputs();
    check("jr_pc", pc_a, 32'h300);
    check("aerr_on", 32'(aerr_a), 32'h1);
    tick();
    check("aerr_off", 32'(aerr_a), 32'h0);

    // 20 back-to-back redirects saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      branch_taken = 1; branch_target = 32'h1000 + 32'(i) * 16;
      tick();
    end
    idle_inputs();
    check("sat4", 32'(cnt_b), 32'hF);

    // Reset while parked
    stall = 1; jr = 1; jr_target = 32'h700;
    tick();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    check("rstp_pc", pc_a, 32'h0);
    check("rstp_pend", 32'(pend_a), 32'h0);
    check("rstp_cnt", 32'(cnt_b), 32'h0);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(99) == 0);
      exception      = ($urandom_range(99) < 3);
      branch_taken   = ($urandom_range(99) < 15);
      jr             = ($urandom_range(99) < 10);
      jump           = ($urandom_range(99) < 10);
      stall          = ($urandom_range(99) < 35);
      branch_target  = $urandom;
      jr_target      = $urandom;
      jump_pc_plus_4 = $urandom;
      jump_index     = 26'($urandom);
      if ($urandom_range(9) == 0) begin
        branch_taken = 0; jr = 0; jump = 0; exception = 0; stall = 0; reset = 0;
        m_pc = m_pc;
      end
      tick();
    end
    idle_inputs();
    reset = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
